llc_rst_flush_seq: RTL
======================

// Module: llc_rst_flush_seq
// PURPOSE
//  Sequencer for LLC reset and flush set-walks. After reset it walks every set and pulses the
//  per-set invalidate update (rst_to_resume). On a flush request it walks every set again:
//  read the set, write back each dirty DATA way to memory (valid/ready), then pulse the per-set
//  flush update. Sits between the LLC input arbiter and the update/writeback datapath.
// PARAMETERS
//  SETS      256  number of LLC sets walked (power of 2)
//  WAYS      16   ways per set
//  SET_BITS  8    clog2(SETS)
//  WAY_BITS  4    clog2(WAYS)
// PORTS
//  clk                 in   1         clock, all logic rising-edge
//  rst                 in   1         synchronous, active-high reset
//  stall               in   1         LLC serving other traffic; hold all outputs' progress
//  flush_req           in   1         one-cycle flush request
//  rd_valid            in   1         set buffers loaded for set_idx (after rd_en)
//  wb_mask             in   WAYS      ways needing writeback (VALID && DATA && dirty), sampled on rd_valid
//  wb_ready            in   1         memory accepts writeback
//  set_idx             out  SET_BITS  set being walked
//  rd_en               out  1         one-cycle set read strobe
//  wb_valid            out  1         writeback request valid
//  wb_way              out  WAY_BITS  way to write back
//  update_en           out  1         one-cycle update strobe
//  is_rst_to_resume    out  1         qualifies update_en as reset invalidate
//  is_flush_to_resume  out  1         qualifies update_en as flush invalidate
//  rst_done            out  1         level, high once reset walk completes
//  flush_busy          out  1         flush walk in progress
//  flush_done          out  1         one-cycle pulse at flush walk completion
// BEHAVIOUR
//  Reset (rst=1 at edge): state=RST_WALK, set_idx=0, pending=0, rst_done=0, flush_busy=0,
//   all strobes/wb_valid=0, wb_mask register=0. Reset mid-walk/mid-writeback aborts immediately;
//   an in-flight wb_valid is dropped (memory side resets with it).
//  States: RST_WALK, IDLE, FL_RD, FL_WAIT, FL_WB, FL_UPD.
//  RST_WALK: each cycle with !stall: update_en=1, is_rst_to_resume=1 for set_idx; set_idx++.
//   After set SETS-1: set_idx wraps to 0, rst_done=1 next cycle, -> IDLE. SETS cycles if no stall.
//  IDLE: if pending or flush_req (and rst_done): clear pending, flush_busy=1, set_idx=0, -> FL_RD.
//  FL_RD: if !stall: rd_en=1 one cycle -> FL_WAIT. Under stall rd_en stays 0.
//  FL_WAIT: on rd_valid latch wb_mask into mask_q; -> FL_WB if mask_q!=0 else FL_UPD.
//  FL_WB: wb_valid=1, wb_way = lowest set bit of mask_q; wb_way/wb_valid held stable until
//   wb_ready. On valid&&ready clear that bit; if resulting mask 0 -> FL_UPD, else next lowest
//   bit presented next cycle (no bubble). stall does not withdraw an asserted wb_valid.
//  FL_UPD: if !stall: update_en=1, is_flush_to_resume=1. If set_idx==SETS-1: set_idx->0,
//   flush_busy=0, flush_done=1 (same cycle as final update), -> IDLE; else set_idx++ -> FL_RD.
//  flush_req while RST_WALK or flushing sets sticky pending (multiple coalesce to one walk);
//   serviced from IDLE next cycle -> back-to-back flush walks possible.
//  is_*_to_resume only high while update_en high; never both. rd_en/update_en never same cycle.
//  Per-set flush latency (no stall, mask has k bits, wb_ready always 1): 1 rd + rd latency + k + 1.
//  set_idx arithmetic modulo SETS (SET_BITS wrap); no out-of-range index ever driven.
// TESTING
//  Reset, SETS=4, stall=0 -> update_en+is_rst_to_resume 4 cycles, set_idx 0,1,2,3; rst_done=1 cycle 5.
//  flush_req, all wb_mask=0, rd_valid 1 cycle after rd_en -> per set rd_en,wait,update; flush_done once, set 3.
//  Set 1 wb_mask=16'h8005, wb_ready toggling 1/0 -> wb_way 0,2,15 in order, each held until ready.
//  flush_req during RST_WALK plus 3 more during flush -> exactly 2 flush walks after rst_done.
//  stall=1 for 5 cycles in RST_WALK and FL_UPD -> no update_en, set_idx frozen, resumes unchanged.
//  rst=1 during FL_WB with wb_valid high -> next cycle wb_valid=0, rst_done=0, reset walk restarts at 0.

Source files
------------

// File: rtl/llc_rst_flush_seq.sv
// LLC reset/flush set-walk sequencer: invalidates every set after reset, and on a flush
// request reads each set, writes back its dirty data ways, then issues the flush update.
//
// state    | meaning
// RST_WALK | issuing reset-invalidate updates, one set per unstalled cycle
// IDLE     | reset walk done, waiting for a (pending) flush request
// FL_RD    | issue the set read strobe
// FL_WAIT  | wait for set buffers, capture writeback mask
// FL_WB    | present dirty ways lowest-first until the mask is empty
// FL_UPD   | issue the flush-invalidate update, advance or finish
module llc_rst_flush_seq #(
  parameter int SETS     = 256,
  parameter int WAYS     = 16,
  parameter int SET_BITS = 8,
  parameter int WAY_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush_req,
  input  logic                rd_valid,
  input  logic [WAYS-1:0]     wb_mask,
  input  logic                wb_ready,
  output logic [SET_BITS-1:0] set_idx,
  output logic                rd_en,
  output logic                wb_valid,
  output logic [WAY_BITS-1:0] wb_way,
  output logic                update_en,
  output logic                is_rst_to_resume,
  output logic                is_flush_to_resume,
  output logic                rst_done,
  output logic                flush_busy,
  output logic                flush_done
);

  typedef enum logic [2:0] {RST_WALK, IDLE, FL_RD, FL_WAIT, FL_WB, FL_UPD} state_t;

  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

  state_t          state;
  logic            pending;
  logic [WAYS-1:0] mask_q;
  logic [WAYS-1:0] mask_nxt;
  logic            last_rst_upd;

  function automatic logic [WAY_BITS-1:0] lowest_way(input logic [WAYS-1:0] m);
    lowest_way = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (m[i]) lowest_way = WAY_BITS'(i);
  endfunction

  always_comb begin
    mask_nxt     = mask_q & ~(WAYS'(1) << wb_way);
    last_rst_upd = update_en && (set_idx == LAST_SET);
  end

  // stall is sampled at the edge; set_idx advances on the edge that ends each update pulse,
  // so every registered strobe is seen alongside the set it applies to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= RST_WALK;
      set_idx            <= '0;
      pending            <= 1'b0;
      mask_q             <= '0;
      rd_en              <= 1'b0;
      wb_valid           <= 1'b0;
      wb_way             <= '0;
      update_en          <= 1'b0;
      is_rst_to_resume   <= 1'b0;
      is_flush_to_resume <= 1'b0;
      rst_done           <= 1'b0;
      flush_busy         <= 1'b0;
      flush_done         <= 1'b0;
    end else begin
      rd_en              <= 1'b0;
      update_en          <= 1'b0;
      is_rst_to_resume   <= 1'b0;
      is_flush_to_resume <= 1'b0;
      flush_done         <= 1'b0;

      if (update_en) set_idx <= set_idx + 1'b1;
      if (flush_req && state != IDLE) pending <= 1'b1;

      case (state)
        RST_WALK: begin
          if (last_rst_upd) begin
            rst_done <= 1'b1;
            state    <= IDLE;
          end else if (!stall) begin
            update_en        <= 1'b1;
            is_rst_to_resume <= 1'b1;
          end
        end
        IDLE: begin
          if (rst_done && (pending || flush_req)) begin
            pending    <= 1'b0;
            flush_busy <= 1'b1;
            set_idx    <= '0;
            state      <= FL_RD;
          end
        end
        FL_RD: begin
          if (!stall) begin
            rd_en <= 1'b1;
            state <= FL_WAIT;
          end
        end
        FL_WAIT: begin
          if (rd_valid) begin
            mask_q <= wb_mask;
            if (|wb_mask) begin
              wb_valid <= 1'b1;
              wb_way   <= lowest_way(wb_mask);
              state    <= FL_WB;
            end else begin
              state <= FL_UPD;
            end
          end
        end
        FL_WB: begin
          if (wb_ready) begin
            mask_q <= mask_nxt;
            if (mask_nxt == '0) begin
              wb_valid <= 1'b0;
              state    <= FL_UPD;
            end else begin
              wb_way <= lowest_way(mask_nxt);
            end
          end
        end
        FL_UPD: begin
          if (!stall) begin
            update_en          <= 1'b1;
            is_flush_to_resume <= 1'b1;
            if (set_idx == LAST_SET) begin
              flush_busy <= 1'b0;
              flush_done <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= FL_RD;
            end
          end
        end
        default: state <= RST_WALK;
      endcase
    end
  end

endmodule
